decode_hazard_ctrl: RTL and testbench
=====================================

Name: decode_hazard_ctrl

Overview:
- Sequencing controller for the decode stage: decides each cycle whether the decoded instruction issues, stalls or is killed.
- Keeps a register scoreboard of long-latency destinations, such as loads. A register is busy from issue of its producer until writeback to the register file.
- Generates stall, bubble and flush controls for fetch, decode and execute.
- Handles the taken-branch redirect sequence, and includes a stall watchdog for debug.

Parameters:
- NUM_REGS, 32, number of architectural registers; x0 is never tracked.
- FLUSH_CYCLES, 1, cycles of fetch flush after a taken branch (range 1..7).
- TIMEOUT, 64, consecutive stall cycles before o_timeout is set (range 2..255).
- WB_BYPASS, 0, 1 = a same-cycle writeback match counts as not busy for the stall decision.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous, active-low reset.
- i_dec_valid  in  1  decode stage holds a valid instruction.
- i_rs1_num  in  5  source register 1 index.
- i_rs2_num  in  5  source register 2 index.
- i_rs1_used  in  1  instruction reads rs1.
- i_rs2_used  in  1  instruction reads rs2.
- i_rd_num  in  5  destination register index.
- i_long_lat  in  1  instruction is long-latency (load); its rd becomes busy.
- i_b_taken  in  1  branch unit reports taken for the current decode instruction.
- i_wb_valid  in  1  register-file write happening this cycle.
- i_wb_rd_num  in  5  register written this cycle.
- o_issue  out  1  decode instruction advances to execute this cycle.
- o_stall  out  1  hold the fetch and decode pipeline registers.
- o_bubble  out  1  insert a NOP into execute.
- o_flush  out  1  invalidate fetch/decode contents (branch redirect).
- o_busy_map  out  32  scoreboard state; bit 0 is always 0.
- o_timeout  out  1  sticky watchdog flag.

Behaviour:
- Reset (i_rst=0, asynchronous):
  - busy_map=0, state=RUN, flush counter=0, stall counter=0, o_timeout=0.
  - All outputs are 0 except o_bubble=1 (execute receives a NOP during reset).
- States: RUN, FLUSH. Stalling is a combinational condition within RUN, not a separate state.
- Hazard condition (hz):
  - hz = i_dec_valid and ((i_rs1_used and busy[rs1]) or (i_rs2_used and busy[rs2])).
  - busy[0] always reads 0.
  - When WB_BYPASS=1, busy[r] is masked by (i_wb_valid and i_wb_rd_num==r).
- RUN:
  - o_issue = i_dec_valid and not hz.
  - o_stall = hz; o_bubble = not o_issue.
  - If o_issue and i_b_taken: o_flush=1 this cycle, next state FLUSH, flush counter loads FLUSH_CYCLES-1.
  - FLUSH_CYCLES=1: return directly to RUN.
  - i_b_taken is ignored whenever o_issue=0; operands are stale during a stall.
- FLUSH:
  - o_flush=1, o_bubble=1, o_issue=0, o_stall=0, i_dec_valid ignored.
  - Counter decrements each cycle; return to RUN on the cycle after the counter reaches 0.
- Scoreboard update, registered at the clock edge:
  - Clear busy[i_wb_rd_num] when i_wb_valid.
  - Set busy[i_rd_num] when o_issue and i_long_lat and rd!=0.
  - Set and clear of the same register in the same cycle: set wins.
  - A writeback to a non-busy register is harmless (no change).
  - Writes to x0 are ignored.
- Latency:
  - Stall release is 1 cycle after the writeback edge with WB_BYPASS=0.
  - Stall release is 0 cycles (same cycle) with WB_BYPASS=1.
- Watchdog:
  - 8-bit stall counter increments when o_stall=1, saturating at 255; clears on any cycle with o_stall=0.
  - When the counter reaches TIMEOUT, o_timeout goes to 1 and stays set until reset.
  - The watchdog does not alter pipeline control.
- Reset mid-flush or mid-stall: immediately returns to the reset state; all pending busy bits are discarded.

Decomposition:
- Shared constants header holds:
  - state encodings ST_RUN=1'b0, ST_FLUSH=1'b1;
  - REG_X0 index;
  - the opcode-to-i_long_lat decode constant (LOAD opcode 7'b0000011), reused by the decode stage.
- One natural sub-module: hazard_scoreboard. It holds the busy register array, the set/clear logic and the two read ports with optional bypass.
- FSM, flush counter and watchdog stay in the top module.

Test Plan:
- Load x5 issues with i_long_lat=1 → busy_map[5]=1 next cycle. Next instruction uses rs1=5 → o_stall=1, o_bubble=1 until i_wb_valid, rd=5. With WB_BYPASS=0, o_issue=1 one cycle after the writeback edge.
- Load with rd=0 issued → busy_map stays 0. Following instruction with rs1=0 → no stall, o_issue=1.
- Taken branch issued, FLUSH_CYCLES=2 → o_flush=1 for 3 consecutive cycles (issue cycle + 2 in FLUSH). o_issue=0 during the FLUSH cycles even with i_dec_valid=1. RUN resumes on the 4th cycle.
- Same-cycle writeback of x7 and issue of a new load to x7 → busy_map[7] remains 1. Writeback of x7 alone → busy_map[7]=0.
- Stall held with no writeback, TIMEOUT=64 → o_timeout=0 through 63 stall cycles, then 1 and remains set after the stall ends. i_rst=0 pulse clears it.
- Assert i_rst mid-FLUSH with busy_map=0x0000_0120 → immediately o_flush=0, busy_map=0, o_bubble=1. After release, the first valid non-hazard instruction issues.

Source files
------------

// File: rtl/decode_hazard_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : decode_hazard_ctrl_pkg                                          |
// | Purpose  : Shared encodings and constants for the decode hazard controller |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package decode_hazard_ctrl_pkg;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  localparam int          REG_IDX_W = 5;
  localparam int          MAP_W     = 32;
  localparam logic [4:0]  REG_X0    = 5'd0;
  localparam logic [6:0]  OPC_LOAD  = 7'b0000011;

  // Decode helper shared with the decode stage to derive i_long_lat.
  function automatic logic is_long_lat(input logic [6:0] opcode);
    return (opcode == OPC_LOAD);
  endfunction

endpackage : decode_hazard_ctrl_pkg
`default_nettype wire

// File: rtl/decode_hazard_ctrl_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : hazard_scoreboard                                               |
// | Purpose  : Busy bits for long-latency destinations, two hazard read ports  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module hazard_scoreboard
  import decode_hazard_ctrl_pkg::*;
#(
  parameter int NUM_REGS  = 32,
  parameter int WB_BYPASS = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_set_en,
  input  logic [4:0]           i_set_num,
  input  logic                 i_clr_en,
  input  logic [4:0]           i_clr_num,
  input  logic [4:0]           i_rs1_num,
  input  logic [4:0]           i_rs2_num,
  output logic                 o_rs1_busy,
  output logic                 o_rs2_busy,
  output logic [NUM_REGS-1:0]  o_busy_map
);

  localparam logic c_bypass = (WB_BYPASS != 0);

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_next;
  logic [NUM_REGS-1:0] w_busy_rd;

  // Set is applied after clear so a same-cycle set of the same register wins.
  always_comb begin
    w_busy_next = r_busy;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (i_clr_en && (i_clr_num == 5'(r))) begin
        w_busy_next[r] = 1'b0;
      end
      if (i_set_en && (i_set_num == 5'(r))) begin
        w_busy_next[r] = 1'b1;
      end
    end
    w_busy_next[REG_X0] = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  always_comb begin
    w_busy_rd = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      w_busy_rd[r] = r_busy[r] & ~(c_bypass & i_clr_en & (i_clr_num == 5'(r)));
    end
  end

  always_comb begin
    o_rs1_busy = 1'b0;
    o_rs2_busy = 1'b0;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (i_rs1_num == 5'(r)) begin
        o_rs1_busy = w_busy_rd[r];
      end
      if (i_rs2_num == 5'(r)) begin
        o_rs2_busy = w_busy_rd[r];
      end
    end
  end

  assign o_busy_map = r_busy;

endmodule : hazard_scoreboard
`default_nettype wire

// File: rtl/decode_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : decode_hazard_ctrl                                              |
// | Purpose  : Decode-stage issue/stall/flush sequencing with stall watchdog   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module decode_hazard_ctrl
  import decode_hazard_ctrl_pkg::*;
#(
  parameter int NUM_REGS     = 32,
  parameter int FLUSH_CYCLES = 1,
  parameter int TIMEOUT      = 64,
  parameter int WB_BYPASS    = 0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_dec_valid,
  input  logic [4:0]   i_rs1_num,
  input  logic [4:0]   i_rs2_num,
  input  logic         i_rs1_used,
  input  logic         i_rs2_used,
  input  logic [4:0]   i_rd_num,
  input  logic         i_long_lat,
  input  logic         i_b_taken,
  input  logic         i_wb_valid,
  input  logic [4:0]   i_wb_rd_num,
  output logic         o_issue,
  output logic         o_stall,
  output logic         o_bubble,
  output logic         o_flush,
  output logic [31:0]  o_busy_map,
  output logic         o_timeout
);

  localparam logic       c_has_flush_st = (FLUSH_CYCLES > 1);
  localparam logic [2:0] c_flush_load   = 3'(FLUSH_CYCLES - 1);
  localparam logic [7:0] c_timeout      = 8'(TIMEOUT);

  state_t              r_state;
  logic [2:0]          r_flush_cnt;
  logic [7:0]          r_stall_cnt;
  logic                r_timeout;

  logic                w_rs1_busy;
  logic                w_rs2_busy;
  logic                w_hz;
  logic                w_run;
  logic                w_issue;
  logic                w_stall;
  logic                w_set_en;
  logic [7:0]          w_stall_cnt_inc;
  logic [NUM_REGS-1:0] w_map;

  hazard_scoreboard #(
    .NUM_REGS  (NUM_REGS),
    .WB_BYPASS (WB_BYPASS)
  ) u_scoreboard (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_set_en   (w_set_en),
    .i_set_num  (i_rd_num),
    .i_clr_en   (i_wb_valid),
    .i_clr_num  (i_wb_rd_num),
    .i_rs1_num  (i_rs1_num),
    .i_rs2_num  (i_rs2_num),
    .o_rs1_busy (w_rs1_busy),
    .o_rs2_busy (w_rs2_busy),
    .o_busy_map (w_map)
  );

  // Gating with i_rst keeps the outputs at their reset values while reset is low.
  assign w_hz     = i_dec_valid & ((i_rs1_used & w_rs1_busy) | (i_rs2_used & w_rs2_busy));
  assign w_run    = i_rst & (r_state == ST_RUN);
  assign w_issue  = w_run & i_dec_valid & ~w_hz;
  assign w_stall  = w_run & w_hz;
  assign w_set_en = w_issue & i_long_lat & (i_rd_num != REG_X0);

  assign o_issue   = w_issue;
  assign o_stall   = w_stall;
  assign o_bubble  = ~w_issue;
  assign o_flush   = (w_issue & i_b_taken) | (i_rst & (r_state == ST_FLUSH));
  assign o_timeout = r_timeout;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state     <= ST_RUN;
      r_flush_cnt <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_issue && i_b_taken && c_has_flush_st) begin
            r_state     <= ST_FLUSH;
            r_flush_cnt <= c_flush_load;
          end
        end
        ST_FLUSH: begin
          if (r_flush_cnt == 3'd0) begin
            r_state <= ST_RUN;
          end else begin
            r_flush_cnt <= r_flush_cnt - 3'd1;
          end
        end
        default: begin
          r_state     <= ST_RUN;
          r_flush_cnt <= '0;
        end
      endcase
    end
  end

  assign w_stall_cnt_inc = (r_stall_cnt == 8'hFF) ? 8'hFF : (r_stall_cnt + 8'd1);

  // Debug-only watchdog; it observes the stall but never feeds back into control.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_stall_cnt <= '0;
      r_timeout   <= 1'b0;
    end else if (w_stall) begin
      r_stall_cnt <= w_stall_cnt_inc;
      if (w_stall_cnt_inc >= c_timeout) begin
        r_timeout <= 1'b1;
      end
    end else begin
      r_stall_cnt <= '0;
    end
  end

  for (genvar i = 0; i < MAP_W; i++) begin : g_map
    if (i < NUM_REGS) begin : g_tracked
      assign o_busy_map[i] = w_map[i];
    end else begin : g_untracked
      assign o_busy_map[i] = 1'b0;
    end
  end

endmodule : decode_hazard_ctrl
`default_nettype wire

// File: tb/tb_decode_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_decode_hazard_ctrl                                           |
// | Purpose  : Directed stimulus, behavioural model compared every cycle       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_decode_hazard_ctrl;

  localparam int TB_FLUSH   = 2;
  localparam int TB_TIMEOUT = 64;
  localparam bit TB_BYPASS  = 1'b0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dec_valid, rs1_used, rs2_used, long_lat, b_taken, wb_valid;
  logic [4:0]  rs1, rs2, rd, wb_rd;
  logic        issue, stall, bubble, flush, timeout;
  logic [31:0] busy_map;

  int n_vec = 0;
  int n_err = 0;

  decode_hazard_ctrl #(
    .NUM_REGS     (32),
    .FLUSH_CYCLES (TB_FLUSH),
    .TIMEOUT      (TB_TIMEOUT),
    .WB_BYPASS    (0)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst_n),
    .i_dec_valid (dec_valid),
    .i_rs1_num   (rs1),
    .i_rs2_num   (rs2),
    .i_rs1_used  (rs1_used),
    .i_rs2_used  (rs2_used),
    .i_rd_num    (rd),
    .i_long_lat  (long_lat),
    .i_b_taken   (b_taken),
    .i_wb_valid  (wb_valid),
    .i_wb_rd_num (wb_rd),
    .o_issue     (issue),
    .o_stall     (stall),
    .o_bubble    (bubble),
    .o_flush     (flush),
    .o_busy_map  (busy_map),
    .o_timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Behavioural model: busy set, remaining redirect cycles, stall run length.
  bit m_busy [32];
  int m_flush_left;
  int m_stall_run;
  bit m_timeout;

  function automatic bit busy_now(input logic [4:0] r);
    return (r != 0) && m_busy[r] && !(TB_BYPASS && wb_valid && (wb_rd == r));
  endfunction

  always @(negedge clk) begin
    bit e_issue, e_stall, e_flush, e_hz;
    logic [31:0] e_map;
    if (!rst_n) begin
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_flush_left = 0;
      m_stall_run  = 0;
      m_timeout    = 1'b0;
    end
    e_hz = dec_valid && ((rs1_used && busy_now(rs1)) || (rs2_used && busy_now(rs2)));
    if (!rst_n || m_flush_left > 0) begin
      e_issue = 1'b0;
      e_stall = 1'b0;
      e_flush = rst_n && (m_flush_left > 0);
    end else begin
      e_issue = dec_valid && !e_hz;
      e_stall = e_hz;
      e_flush = e_issue && b_taken;
    end
    for (int i = 0; i < 32; i++) e_map[i] = m_busy[i];
    check("issue",    {31'd0, issue},   {31'd0, e_issue});
    check("stall",    {31'd0, stall},   {31'd0, e_stall});
    check("bubble",   {31'd0, bubble},  {31'd0, !e_issue});
    check("flush",    {31'd0, flush},   {31'd0, e_flush});
    check("busy_map", busy_map,         e_map);
    check("timeout",  {31'd0, timeout}, {31'd0, m_timeout});
    if (rst_n) begin
      if (m_flush_left > 0) m_flush_left--;
      else if (e_issue && b_taken) m_flush_left = (TB_FLUSH > 1) ? TB_FLUSH : 0;
      if (wb_valid && wb_rd != 0) m_busy[wb_rd] = 1'b0;
      if (e_issue && long_lat && rd != 0) m_busy[rd] = 1'b1;
      m_stall_run = e_stall ? ((m_stall_run < 255) ? m_stall_run + 1 : 255) : 0;
      if (m_stall_run >= TB_TIMEOUT) m_timeout = 1'b1;
    end
  end

  // One cycle: drive just after the rising edge, return just after the falling edge.
  task automatic cyc(input logic r, input logic v, input logic [4:0] a, input logic ua,
                     input logic [4:0] b, input logic ub, input logic [4:0] d,
                     input logic ll, input logic bt, input logic wv, input logic [4:0] wr);
    @(posedge clk); #1;
    rst_n = r; dec_valid = v; rs1 = a; rs1_used = ua; rs2 = b; rs2_used = ub;
    rd = d; long_lat = ll; b_taken = bt; wb_valid = wv; wb_rd = wr;
    @(negedge clk); #1;
  endtask

  task automatic nop();
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL time_limit: got no finish, required finish");
    $fatal(1, "time limit");
  end

  initial begin
    int nflush;
    rst_n = 0; dec_valid = 0; rs1 = 0; rs2 = 0; rs1_used = 0; rs2_used = 0;
    rd = 0; long_lat = 0; b_taken = 0; wb_valid = 0; wb_rd = 0;

    // Reset with a valid instruction present: outputs must stay at reset values.
    cyc(0, 1, 1, 1, 2, 1, 3, 1, 1, 0, 0);
    check("rst_bubble", {31'd0, bubble}, 32'd1);
    check("rst_issue",  {31'd0, issue},  32'd0);
    check("rst_map",    busy_map,        32'd0);
    nop();

    // Load x5, then a consumer of x5 stalls until one cycle after writeback.
    cyc(1, 1, 1, 1, 2, 1, 5, 1, 0, 0, 0);
    check("ld5_issue", {31'd0, issue}, 32'd1);
    cyc(1, 1, 5, 1, 0, 0, 6, 0, 0, 0, 0);
    check("ld5_map",   busy_map,       32'h0000_0020);
    check("use5_stall", {31'd0, stall}, 32'd1);
    cyc(1, 1, 5, 1, 0, 0, 6, 0, 0, 0, 0);
    cyc(1, 1, 5, 1, 0, 0, 6, 0, 0, 1, 5);
    check("wb5_still_stall", {31'd0, stall}, 32'd1);
    cyc(1, 1, 5, 1, 0, 0, 6, 0, 0, 0, 0);
    check("use5_issue", {31'd0, issue}, 32'd1);
    check("wb5_map",    busy_map,       32'd0);

    // Load to x0 is not tracked.
    cyc(1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    cyc(1, 1, 0, 1, 0, 0, 3, 0, 0, 0, 0);
    check("x0_map",   busy_map,       32'd0);
    check("x0_issue", {31'd0, issue}, 32'd1);

    // Taken branch: issue cycle plus two redirect cycles of flush.
    nflush = 0;
    cyc(1, 1, 1, 1, 2, 1, 4, 0, 1, 0, 0);
    nflush += int'(flush);
    check("br_issue", {31'd0, issue}, 32'd1);
    for (int i = 0; i < 2; i++) begin
      cyc(1, 1, 1, 1, 2, 1, 4, 0, 1, 0, 0);
      nflush += int'(flush);
      check("br_flush_noissue", {31'd0, issue}, 32'd0);
    end
    check("br_flush_count", nflush, 32'd3);
    cyc(1, 1, 1, 1, 2, 1, 4, 0, 0, 0, 0);
    check("br_resume_flush", {31'd0, flush}, 32'd0);
    check("br_resume_issue", {31'd0, issue}, 32'd1);

    // Same-cycle writeback and re-issue of x7: set wins.
    cyc(1, 1, 1, 1, 0, 0, 7, 1, 0, 0, 0);
    cyc(1, 1, 1, 1, 0, 0, 7, 1, 0, 1, 7);
    nop();
    check("x7_set_wins", busy_map, 32'h0000_0080);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7);
    nop();
    check("x7_cleared", busy_map, 32'd0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 12);
    check("wb_nonbusy", busy_map, 32'd0);

    // Watchdog: hold a stall on x9 with no writeback.
    cyc(1, 1, 0, 0, 0, 0, 9, 1, 0, 0, 0);
    for (int i = 0; i < 64; i++) cyc(1, 1, 0, 0, 9, 1, 10, 0, 0, 0, 0);
    check("wd_after63", {31'd0, timeout}, 32'd0);
    cyc(1, 1, 0, 0, 9, 1, 10, 0, 0, 0, 0);
    check("wd_after64", {31'd0, timeout}, 32'd1);
    for (int i = 0; i < 6; i++) cyc(1, 1, 0, 0, 9, 1, 10, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 9, 1, 10, 0, 0, 1, 9);
    cyc(1, 1, 0, 0, 9, 1, 10, 0, 0, 0, 0);
    check("wd_sticky", {31'd0, timeout}, 32'd1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("wd_reset", {31'd0, timeout}, 32'd0);

    // Reset during a redirect with x5 and x8 busy.
    cyc(1, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    cyc(1, 1, 1, 1, 0, 0, 8, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 2, 0, 1, 0, 0);
    check("pre_rst_map", busy_map, 32'h0000_0120);
    cyc(0, 1, 0, 0, 0, 0, 2, 0, 0, 0, 0);
    check("midflush_rst_flush",  {31'd0, flush},  32'd0);
    check("midflush_rst_map",    busy_map,        32'd0);
    check("midflush_rst_bubble", {31'd0, bubble}, 32'd1);
    cyc(1, 1, 5, 1, 8, 1, 3, 0, 0, 0, 0);
    check("post_rst_issue", {31'd0, issue}, 32'd1);

    nop();
    nop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_decode_hazard_ctrl
`default_nettype wire
